// File: rtl/bvshl_inv_witness_search.sv
// bvshl_inv_witness_search
//   Sequential witness search for shift-left invertibility conditions.
//   For a query (op, s, t) it tries x = 0, 1, 2, ... one candidate per clock
//   and returns the smallest x with ((x << s) mod 2**W) OP t. It gives up
//   after LIMIT candidates.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   query present            in_ready   block can accept a query
//   in_op      00 NE, 01 EQ, 10 ULT, 11 UGT (unsigned compares)
//   in_s       shift amount             in_t       target value
//   out_valid  result present           out_ready  consumer takes result
//   out_x      witness (0 if none)      out_found  witness exists
//   out_iters  candidates evaluated
//
// State table
//   state    | meaning
//   S_IDLE   | waiting for a query, in_ready high
//   S_SEARCH | evaluating candidate r_cnt each cycle
//   S_DONE   | result held on outputs until out_valid & out_ready
module bvshl_inv_witness_search #(
  parameter int W     = 4,
  parameter int LIMIT = 2 ** W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [1:0]   in_op,
  input  logic [W-1:0] in_s,
  input  logic [W-1:0] in_t,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_x,
  output logic         out_found,
  output logic [W:0]   out_iters
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SEARCH = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  localparam logic [1:0] OP_NE  = 2'b00;
  localparam logic [1:0] OP_EQ  = 2'b01;
  localparam logic [1:0] OP_ULT = 2'b10;
  localparam logic [1:0] OP_UGT = 2'b11;

  // Counter is one bit wider than x so that LIMIT = 2**W is representable.
  localparam logic [W:0] LP_LAST  = (W+1)'(LIMIT - 1);
  localparam logic [W:0] LP_LIMIT = (W+1)'(LIMIT);

  logic [1:0]   r_state;
  logic [1:0]   r_op;
  logic [W-1:0] r_s;
  logic [W-1:0] r_t;
  logic [W:0]   r_cnt;
  logic [W-1:0] r_x;
  logic         r_found;
  logic [W:0]   r_iters;

  logic [W-1:0] w_c;
  logic [W-1:0] w_sh;
  logic         w_hit;

  // Candidates never exceed LIMIT-1 <= 2**W-1, so the low W bits are exact.
  assign w_c  = r_cnt[W-1:0];
  // Shifting a W-bit value by s >= W leaves nothing; made explicit here.
  assign w_sh = (int'(r_s) >= W) ? '0 : (w_c << r_s);

  always_comb begin
    w_hit = 1'b0;
    case (r_op)
      OP_NE:   w_hit = (w_sh != r_t);
      OP_EQ:   w_hit = (w_sh == r_t);
      OP_ULT:  w_hit = (w_sh <  r_t);
      OP_UGT:  w_hit = (w_sh >  r_t);
      default: w_hit = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_op    <= '0;
      r_s     <= '0;
      r_t     <= '0;
      r_cnt   <= '0;
      r_x     <= '0;
      r_found <= 1'b0;
      r_iters <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_op    <= in_op;
            r_s     <= in_s;
            r_t     <= in_t;
            r_cnt   <= '0;
            r_state <= S_SEARCH;
          end
        end
        S_SEARCH: begin
          if (w_hit) begin
            r_x     <= w_c;
            r_found <= 1'b1;
            r_iters <= r_cnt + (W+1)'(1);
            r_state <= S_DONE;
          end else if (r_cnt == LP_LAST) begin
            r_x     <= '0;
            r_found <= 1'b0;
            r_iters <= LP_LIMIT;
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt + (W+1)'(1);
          end
        end
        S_DONE: begin
          if (out_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign out_x     = r_x;
  assign out_found = r_found;
  assign out_iters = r_iters;

endmodule

// File: tb/tb_bvshl_inv_witness_search.sv
module tb_bvshl_inv_witness_search;

  logic       clk;
  logic       rst_n;

  logic       in_valid, in_ready, out_valid, out_ready, out_found;
  logic [1:0] in_op;
  logic [3:0] in_s, in_t, out_x;
  logic [4:0] out_iters;

  logic       in_valid8, in_ready8, out_valid8, out_ready8, out_found8;
  logic [1:0] in_op8;
  logic [7:0] in_s8, in_t8, out_x8;
  logic [8:0] out_iters8;

  int n_checks;
  int n_fail;

  bvshl_inv_witness_search #(.W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_s(in_s), .in_t(in_t),
    .out_valid(out_valid), .out_ready(out_ready), .out_x(out_x),
    .out_found(out_found), .out_iters(out_iters)
  );

  bvshl_inv_witness_search #(.W(8), .LIMIT(16)) dut8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid8), .in_ready(in_ready8), .in_op(in_op8),
    .in_s(in_s8), .in_t(in_t8),
    .out_valid(out_valid8), .out_ready(out_ready8), .out_x(out_x8),
    .out_found(out_found8), .out_iters(out_iters8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: brute-force scan of candidates with plain integer arithmetic.
  function automatic void model(input int w, input int lim, input int op,
                                input int s, input int t,
                                output int x, output int found, output int iters);
    longint sh;
    bit     hit;
    found = 0;
    x     = 0;
    iters = lim;
    for (int k = 0; k < lim; k++) begin
      if (found == 0) begin
        sh = (s >= w) ? 0 : ((longint'(k) << s) % (longint'(1) << w));
        case (op)
          0: hit = (sh != t);
          1: hit = (sh == t);
          2: hit = (sh < t);
          default: hit = (sh > t);
        endcase
        if (hit) begin
          found = 1;
          x     = k;
          iters = k + 1;
        end
      end
    end
  endfunction

  task automatic query4(input int op, input int s, input int t, input int bp);
    int ex, ef, ei, n;
    logic [3:0] hx;
    logic       hf;
    logic [4:0] hi;
    model(4, 16, op, s, t, ex, ef, ei);
    @(negedge clk);
    in_valid = 1'b1;
    in_op = 2'(op);
    in_s  = 4'(s);
    in_t  = 4'(t);
    chk("ready_before_accept", int'(in_ready), 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    // Scramble inputs; the latched query must be unaffected.
    in_op = 2'($urandom);
    in_s  = 4'($urandom);
    in_t  = 4'($urandom);
    chk("ready_in_search", int'(in_ready), 0);
    n = 0;
    while (!out_valid && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("latency", n, ei);
    chk("out_x", int'(out_x), ex);
    chk("out_found", int'(out_found), ef);
    chk("out_iters", int'(out_iters), ei);
    hx = out_x;
    hf = out_found;
    hi = out_iters;
    for (int i = 0; i < bp; i++) begin
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      chk("bp_valid", int'(out_valid), 1);
      chk("bp_ready", int'(in_ready), 0);
      chk("bp_stable", int'({hx, hf, hi} == {out_x, out_found, out_iters}), 1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("post_hs_valid", int'(out_valid), 0);
    chk("post_hs_ready", int'(in_ready), 1);
  endtask

  task automatic query8(input int op, input int s, input int t);
    int ex, ef, ei, n;
    model(8, 16, op, s, t, ex, ef, ei);
    @(negedge clk);
    in_valid8 = 1'b1;
    in_op8 = 2'(op);
    in_s8  = 8'(s);
    in_t8  = 8'(t);
    @(posedge clk);
    #1;
    in_valid8 = 1'b0;
    n = 0;
    while (!out_valid8 && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("w8_latency", n, ei);
    chk("w8_out_x", int'(out_x8), ex);
    chk("w8_found", int'(out_found8), ef);
    chk("w8_iters", int'(out_iters8), ei);
    out_ready8 = 1'b1;
    @(posedge clk);
    #1;
    out_ready8 = 1'b0;
    chk("w8_post_hs_ready", int'(in_ready8), 1);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n = 1'b0;
    in_valid = 1'b0; in_op = '0; in_s = '0; in_t = '0; out_ready = 1'b0;
    in_valid8 = 1'b0; in_op8 = '0; in_s8 = '0; in_t8 = '0; out_ready8 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_x", int'(out_x), 0);
    chk("rst_out_found", int'(out_found), 0);
    chk("rst_out_iters", int'(out_iters), 0);
    @(negedge clk);
    rst_n = 1'b1;
    // No accept yet: out_valid must stay low.
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      chk("idle_no_valid", int'(out_valid), 0);
    end

    // Directed cases.
    query4(0, 0, 0, 0);        // NE: x=1
    query4(1, 2, 12, 0);       // EQ: x=3
    query4(1, 2, 6, 0);        // EQ: none, 16 iters
    query4(3, 3, 7, 0);        // UGT: x=1
    query4(2, 3, 0, 0);        // ULT t=0: none
    query4(0, 5, 0, 0);        // NE with s>=W: none
    query4(1, 5, 0, 0);        // EQ with s>=W: x=0
    query4(2, 1, 15, 3);       // backpressure
    query4(1, 2, 12, 0);       // leaves nonzero outputs before reset test

    // Randomized queries.
    for (int i = 0; i < 24; i++)
      query4(int'($urandom_range(0, 3)), int'($urandom_range(0, 15)),
             int'($urandom_range(0, 15)), int'($urandom_range(0, 2)));

    // Reset in the middle of the EQ/0110 search.
    @(negedge clk);
    in_valid = 1'b1; in_op = 2'd1; in_s = 4'd2; in_t = 4'd6;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", int'(in_ready), 1);
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_out_x", int'(out_x), 0);
    chk("midrst_out_found", int'(out_found), 0);
    chk("midrst_out_iters", int'(out_iters), 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      chk("postrst_no_valid", int'(out_valid), 0);
    end
    query4(0, 0, 0, 0);

    // Wider operand, reduced limit.
    query8(1, 0, 200);
    query8(3, 4, 100);
    for (int i = 0; i < 6; i++)
      query8(int'($urandom_range(0, 3)), int'($urandom_range(0, 9)),
             int'($urandom_range(0, 255)));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bvshl_inv_witness_search.md
Name: bvshl_inv_witness_search

Overview:
- Sequential, parametrised successor to the fixed-width combinational shift-left invertibility Skolem functions.
- Given shift amount s, target t and a predicate select, searches candidates x = 0, 1, 2, … and returns the smallest x satisfying (x << s) OP t, or reports that no witness exists.
- Sits behind the constraint-check front end; it is fed one query at a time over a valid/ready handshake.
- One candidate is evaluated per clock.

Parameters:
- W, 4, operand width of x, s, t (legal 2..16).
- LIMIT, 2**W, maximum candidates evaluated before giving up (1..2**W).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  query present.
- in_ready  out  1  block can accept a query.
- in_op  in  2  predicate: 00 NE, 01 EQ, 10 ULT, 11 UGT (all unsigned).
- in_s  in  W  shift amount.
- in_t  in  W  target value.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts result.
- out_x  out  W  witness (0 when not found).
- out_found  out  1  1 = witness exists within LIMIT.
- out_iters  out  W+1  number of candidates evaluated.

Behaviour:
- States: IDLE, SEARCH, DONE. Reset forces state IDLE.
- Reset values: in_ready=1, out_valid=0, out_x=0, out_found=0, out_iters=0, candidate counter=0.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready, register op/s/t, clear counter, go to SEARCH.
- SEARCH:
  - in_ready=0. Each cycle evaluate the candidate c = counter.
  - Shift rule: sh = (c << s) truncated to W bits. If s >= W, sh = 0.
  - Hit rule: sh != t (NE), sh == t (EQ), sh < t (ULT), sh > t (UGT).
  - On hit: out_x=c, out_found=1, out_iters=c+1, go to DONE.
  - On miss with c == LIMIT-1: out_x=0, out_found=0, out_iters=LIMIT, go to DONE.
  - Otherwise counter increments.
- Latency: for accept at edge E0 and smallest witness k, out_valid is high after edge E0+k+1. With no witness, out_valid is high after edge E0+LIMIT.
- DONE:
  - out_valid=1; out_x, out_found and out_iters are held stable until out_valid&out_ready.
  - On that handshake, go to IDLE.
  - in_ready stays 0 in DONE, so there is no overlap between result and next accept. The next accept is possible one cycle after the output handshake.
- The counter is W+1 bits wide so that LIMIT=2**W does not wrap.
- in_* values are ignored outside the accept cycle; changing them mid-search has no effect.
- rst_n asserted mid-SEARCH or mid-DONE: immediate return to reset values. The pending query is discarded and no out_valid is produced.
- out_valid must never rise without a prior accept since reset.

Test Plan:
- W=4, NE, s=0, t=0: accept -> out_x=1, found=1, iters=2; out_valid high 2 edges after accept.
- W=4, EQ, s=2, t=4'b1100 -> out_x=3, found=1, iters=4. Repeat with t=4'b0110 -> found=0, out_x=0, iters=16; out_valid 16 edges after accept.
- W=4, UGT, s=3, t=7 -> out_x=1, found=1, iters=2. ULT with t=0 -> found=0, iters=16.
- W=4, NE, s=5, t=0 (shift >= W gives 0) -> found=0, iters=16. EQ, s=5, t=0 -> out_x=0, found=1, iters=1.
- Backpressure: hold out_ready=0 for 3 cycles in DONE -> outputs stable and in_ready=0 throughout; in_valid offered during DONE is not accepted. After the handshake, in_ready=1 the next cycle.
- Reset: assert rst_n=0 during SEARCH of the EQ/0110 query at iteration 5 -> all outputs at reset values immediately. After release, a fresh NE/s=0/t=0 query returns out_x=1. Also run W=8 with LIMIT=16: EQ, s=0, t=200 -> found=0, iters=16.
